// File: rtl/bitplane_feeder.sv
// Bit-plane serializer feeding the 32-lane adder tree: one vector per 4-cycle frame,
// activations emitted MSB plane first, each lane gating its weight by the current activation bit.

module bitplane_lane #(
  parameter int ABITS = 4,
  parameter int WBITS = 4
) (
  input  logic [ABITS-1:0]         act,
  input  logic [WBITS-1:0]         wgt,
  input  logic [$clog2(ABITS)-1:0] sel,
  output logic [WBITS-1:0]         term
);
  assign term = act[sel] ? wgt : '0;
endmodule

module bitplane_feeder #(
  parameter int LANES = 32,
  parameter int ABITS = 4,
  parameter int WBITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ABITS-1:0] act,
  input  logic [LANES*WBITS-1:0] wgt,
  output logic [LANES*WBITS-1:0] tw,
  output logic                   tw_valid,
  output logic [1:0]             tw_bit,
  output logic                   tw_first,
  output logic                   tw_last
);
  typedef struct packed {
    logic [LANES-1:0][ABITS-1:0] act;
    logic [LANES-1:0][WBITS-1:0] wgt;
  } vec_t;

  logic [1:0] plane_sel, sel_nx;
  vec_t       cur_q, cur_nx, pend_q, pend_nx, in_vec;
  logic       act_valid, act_valid_nx, pend_valid, pend_valid_nx;
  logic       boundary, accept;
  logic [LANES-1:0][WBITS-1:0] term_nx;

  assign in_vec.act = act;
  assign in_vec.wgt = wgt;
  assign boundary   = (plane_sel == 2'd0);
  assign in_ready   = !pend_valid || boundary;
  assign accept     = in_valid && in_ready;
  assign sel_nx     = boundary ? 2'd3 : plane_sel - 2'd1;

  // Pending always drains before a same-edge input, so vectors leave in arrival order.
  always_comb begin
    cur_nx        = cur_q;
    pend_nx       = pend_q;
    act_valid_nx  = act_valid;
    pend_valid_nx = pend_valid;
    if (boundary) begin
      if (pend_valid) begin
        cur_nx        = pend_q;
        act_valid_nx  = 1'b1;
        pend_valid_nx = accept;
        if (accept) pend_nx = in_vec;
      end else if (accept) begin
        cur_nx       = in_vec;
        act_valid_nx = 1'b1;
      end else begin
        act_valid_nx = 1'b0;
      end
    end else if (accept) begin
      pend_nx       = in_vec;
      pend_valid_nx = 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bitplane_lane #(.ABITS(ABITS), .WBITS(WBITS)) u_lane (
      .act  (cur_nx.act[k]),
      .wgt  (cur_nx.wgt[k]),
      .sel  (sel_nx),
      .term (term_nx[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plane_sel  <= 2'd0;
      cur_q      <= '0;
      pend_q     <= '0;
      act_valid  <= 1'b0;
      pend_valid <= 1'b0;
      tw         <= '0;
    end else begin
      plane_sel  <= sel_nx;
      cur_q      <= cur_nx;
      pend_q     <= pend_nx;
      act_valid  <= act_valid_nx;
      pend_valid <= pend_valid_nx;
      tw         <= act_valid_nx ? term_nx : '0;
    end
  end

  assign tw_valid = act_valid;
  assign tw_bit   = plane_sel;
  assign tw_first = act_valid && (plane_sel == 2'd3);
  assign tw_last  = act_valid && (plane_sel == 2'd0);
endmodule

// File: tb/tb_bitplane_feeder.sv
// Self-checking bench: a vector-queue model of the feeder compared every cycle,
// plus directed scenarios with hand-computed literal results.

module tb_bitplane_feeder;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [127:0] act = '0, wgt = '0;
  logic         in_ready, tw_valid, tw_first, tw_last;
  logic [127:0] tw;
  logic [1:0]   tw_bit;

  always #5 clk = ~clk;

  bitplane_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wgt(wgt), .tw(tw), .tw_valid(tw_valid), .tw_bit(tw_bit),
    .tw_first(tw_first), .tw_last(tw_last)
  );

  typedef struct { logic [127:0] a; logic [127:0] w; } vec_t;
  vec_t q[$];
  vec_t cur, tmp;
  bit   cur_v = 0;
  int   bit_m = 0;
  bit   rdy_m;
  int   n_cmp = 0, n_bad = 0;
  int   run = 0, maxrun = 0;

  function automatic logic [127:0] gate(vec_t v, int b);
    logic [127:0] t;
    t = '0;
    for (int k = 0; k < 32; k++)
      t[4*k +: 4] = v.a[4*k + b] ? v.w[4*k +: 4] : 4'd0;
    return t;
  endfunction

  // A transfer is possible when nothing is waiting behind the active frame, or at a frame boundary.
  function automatic bit m_ready();
    return (q.size() == 0) || (bit_m == 0);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    q.delete();
    cur_v = 0;
    bit_m = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      rdy_m = m_ready();
      if (in_valid && rdy_m) begin
        tmp.a = act; tmp.w = wgt;
        q.push_back(tmp);
      end
      if (bit_m == 0) begin
        bit_m = 3;
        if (q.size() > 0) begin cur = q.pop_front(); cur_v = 1; end
        else cur_v = 0;
      end else bit_m--;
    end
    #1;
    chk("tw", tw, cur_v ? gate(cur, bit_m) : 128'd0);
    chk("tw_valid", tw_valid, cur_v);
    chk("tw_bit", tw_bit, bit_m);
    chk("tw_first", tw_first, cur_v && bit_m == 3);
    chk("tw_last", tw_last, cur_v && bit_m == 0);
    chk("in_ready", in_ready, m_ready());
    run = tw_valid ? run + 1 : 0;
    if (run > maxrun) maxrun = run;
  end

  task automatic align0();
    for (int i = 0; i < 8 && bit_m != 0; i++) @(negedge clk);
  endtask

  // Offers a vector and returns on the negedge after it transfers; in_valid stays high.
  task automatic send(input logic [127:0] a, input logic [127:0] w);
    bit ok;
    act = a; wgt = w; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok = m_ready();
      @(negedge clk);
      if (ok) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: got no transfer expected transfer within 20 cycles");
  endtask

  int unsigned osum, psum;
  logic [3:0]  lane0_exp [4];

  initial begin
    lane0_exp[0] = 4'd3; lane0_exp[1] = 4'd0; lane0_exp[2] = 4'd3; lane0_exp[3] = 4'd0;

    // reset held 3 cycles
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tw", tw, 0);
    chk("rst_valid", tw_valid, 0);
    chk("rst_bit", tw_bit, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("init_bit", tw_bit, 3 - i);
      chk("init_valid", tw_valid, 0);
    end

    // all 15: downstream O = P + 2*O gives 480*15 = 7200
    align0();
    send({128{1'b1}}, {128{1'b1}});
    in_valid = 1'b0;
    osum = 0;
    for (int p = 0; p < 4; p++) begin
      psum = 0;
      for (int k = 0; k < 32; k++) psum += tw[4*k +: 4];
      osum = psum + 2 * osum;
      if (p == 0) chk("full_first", tw_first, 1);
      if (p == 3) chk("full_last", tw_last, 1);
      @(negedge clk);
    end
    chk("full_dsum", osum, 7200);

    // lane 0 act=1010 wgt=3
    align0();
    send(128'ha, 128'h3);
    in_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      chk("lane0_term", tw[3:0], lane0_exp[p]);
      chk("lane0_others", tw[127:4], 0);
      @(negedge clk);
    end

    // back-to-back A, B, C with in_valid held
    repeat (4) @(negedge clk);
    align0();
    maxrun = 0;
    send(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    send(128'h5a5a_5a5a_a5a5_a5a5_0f0f_f0f0_3c3c_c3c3, 128'hffff_0000_ffff_0000_1234_5678_9abc_def0);
    send(128'h8888_4444_2222_1111_9999_6666_cccc_3333, 128'h7777_7777_eeee_eeee_0000_1111_abcd_ef01);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_run", maxrun, 12);

    // starvation: one vector then idle gives an empty frame
    align0();
    send(128'hffff_ffff_0000_0000_ffff_ffff_0000_0000, 128'h9);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("starve_valid", tw_valid, 0);
      chk("starve_tw", tw, 0);
      chk("starve_bit", tw_bit, 3 - i);
    end

    // reset at tw_bit==2 with pending full
    align0();
    send({128{1'b1}}, 128'h5);
    send(128'h3, 128'h6);
    in_valid = 1'b0;
    chk("pre_rst_bit", tw_bit, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tw", tw, 0);
    chk("mid_rst_valid", tw_valid, 0);
    chk("mid_rst_bit", tw_bit, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    maxrun = 0;
    repeat (8) @(negedge clk);
    chk("no_stale", maxrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
